beta_irq_controller: RTL and testbench

- Interrupt controller for the unpipelined Beta core.
- Collects up to N_SRC peripheral interrupt lines, latches rising edges as pending, applies a software-writable enable mask and fixed priority, and drives the single IRQ input of the CU.
- Tracks the handshake with the CU: request → taken (CU executes PCSEL=3'b100, WASEL=1 writing XP) → in-service → end-of-interrupt written by the handler.
- Memory-mapped config port sits on the data-memory bus alongside MWR/MOE decoding.

---
 rtl/beta_irq_controller.sv | 150 +++++++++++++++
 tb/tb_beta_irq_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/beta_irq_controller.sv
// Interrupt controller for the unpipelined Beta core: captures rising edges,
// masks and prioritises them, and runs the IRQ request/service handshake with the CU.
module beta_irq_controller #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] SRC,
    input  logic             SUPERVISOR,
    input  logic             IRQ_TAKEN,
    input  logic             CFG_WE,
    input  logic [1:0]       CFG_ADDR,
    input  logic [31:0]      CFG_WDATA,
    output logic [31:0]      CFG_RDATA,
    output logic             IRQ,
    output logic [ID_W-1:0]  IRQ_ID,
    output logic             IRQ_ACTIVE
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  src_q;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [N_SRC-1:0]  enable_q, enable_d;
    logic              irq_q, irq_d;
    logic [ID_W-1:0]   irq_id_q, irq_id_d;
    logic              active_q, active_d;

    logic              wr_pend, wr_en, wr_eoi;
    logic [N_SRC-1:0]  rise, w1c_mask, take_mask, candidate;
    logic [ID_W-1:0]   win_idx;
    logic              win_any;
    logic              held_ok;

    assign wr_pend = CFG_WE && (CFG_ADDR == 2'd0);
    assign wr_en   = CFG_WE && (CFG_ADDR == 2'd1);
    assign wr_eoi  = CFG_WE && (CFG_ADDR == 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            assign rise[gi]      = SRC[gi] & ~src_q[gi];
            assign w1c_mask[gi]  = wr_pend & CFG_WDATA[gi];
            assign take_mask[gi] = (state_q == ST_REQUEST) && IRQ_TAKEN &&
                                   (irq_id_q == ID_W'(gi));
        end
        if (N_SRC < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^CFG_WDATA[31:N_SRC];
        end
    endgenerate

    // Set wins over both software clear and the take-time clear.
    assign pending_d = (pending_q & ~(w1c_mask | take_mask)) | rise;
    assign enable_d  = wr_en ? CFG_WDATA[N_SRC-1:0] : enable_q;
    assign candidate = pending_q & enable_q;
    assign win_any   = |candidate;
    // Withdrawal looks at next-cycle mask/pending so a masked source drops IRQ at once.
    assign held_ok   = pending_d[irq_id_q] & enable_d[irq_id_q];

    always_comb begin
        win_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (candidate[i]) win_idx = ID_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        active_d = active_q;
        case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (win_any && !SUPERVISOR) begin
                    state_d  = ST_REQUEST;
                    irq_d    = 1'b1;
                    irq_id_d = win_idx;
                end
            end
            ST_REQUEST: begin
                if (IRQ_TAKEN) begin
                    state_d  = ST_SERVICE;
                    irq_d    = 1'b0;
                    active_d = 1'b1;
                end else if (!held_ok || SUPERVISOR) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                irq_d    = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= SRC;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        CFG_RDATA = '0;
        case (CFG_ADDR)
            2'd0: CFG_RDATA = 32'(pending_q);
            2'd1: CFG_RDATA = 32'(enable_q);
            2'd2: CFG_RDATA = {active_q, 28'b0, 1'b0, state_q};
            default: begin
                CFG_RDATA[31]       = irq_q;
                CFG_RDATA[30]       = active_q;
                CFG_RDATA[ID_W-1:0] = irq_id_q;
            end
        endcase
    end

    assign IRQ        = irq_q;
    assign IRQ_ID     = irq_id_q;
    assign IRQ_ACTIVE = active_q;

endmodule

// File: tb/tb_beta_irq_controller.sv
// Scoreboard bench for beta_irq_controller: a behavioural model predicts outputs,
// a monitor compares them against the DUT each half cycle.
module tb_beta_irq_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1, sup = 1'b0, tk = 1'b0, we = 1'b0;
    logic [7:0]  src = 8'h00;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rdata;
    logic        irq, act;
    logic [2:0]  id;

    always #5 clk = ~clk;

    beta_irq_controller #(.N_SRC(8), .ID_W(3)) dut (
        .CLK(clk), .RESET(rst), .SRC(src), .SUPERVISOR(sup), .IRQ_TAKEN(tk),
        .CFG_WE(we), .CFG_ADDR(addr), .CFG_WDATA(wd), .CFG_RDATA(rdata),
        .IRQ(irq), .IRQ_ID(id), .IRQ_ACTIVE(act)
    );

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    logic [31:0] pre_q[$];
    logic [36:0] post_q[$];

    // Reference state: 0 = idle, 1 = request, 2 = service
    logic [7:0] m_pend = 8'h0, m_en = 8'h0, m_src = 8'h0;
    logic [1:0] m_st = 2'd0;
    logic       m_irq = 1'b0, m_act = 1'b0;
    logic [2:0] m_id = 3'd0;
    bit         m_valid = 1'b0;

    logic [7:0] cur_src = 8'h00;
    logic       cur_sup = 1'b0;

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'b0, m_pend};
            2'd1:    return {24'b0, m_en};
            2'd2:    return {m_act, 28'b0, 1'b0, m_st};
            default: return {m_irq, m_act, 27'b0, m_id};
        endcase
    endfunction

    task automatic m_step(input logic r, input logic [7:0] s, input logic su, input logic tki,
                          input logic w, input logic [1:0] a, input logic [31:0] d);
        logic [7:0] rise, clear, npend, nen;
        int win;
        if (r) begin
            m_pend = 8'h0; m_en = 8'h0; m_src = 8'h0; m_st = 2'd0;
            m_irq = 1'b0; m_act = 1'b0; m_id = 3'd0;
            return;
        end
        rise  = s & ~m_src;
        clear = (w && a == 2'd0) ? d[7:0] : 8'h0;
        nen   = (w && a == 2'd1) ? d[7:0] : m_en;
        if (m_st == 2'd1 && tki) clear[m_id] = 1'b1;
        npend = (m_pend & ~clear) | rise;
        case (m_st)
            2'd0: begin
                win = -1;
                for (int i = 7; i >= 0; i--) if (m_pend[i] && m_en[i]) win = i;
                if (win >= 0 && !su) begin
                    m_st = 2'd1; m_irq = 1'b1; m_id = 3'(win);
                end
            end
            2'd1: begin
                if (tki) begin
                    m_st = 2'd2; m_irq = 1'b0; m_act = 1'b1;
                end else if (!(npend[m_id] && nen[m_id]) || su) begin
                    m_st = 2'd0; m_irq = 1'b0;
                end
            end
            default: begin
                if (w && a == 2'd2) begin
                    m_st = 2'd0; m_act = 1'b0;
                end
            end
        endcase
        m_pend = npend;
        m_en   = nen;
        m_src  = s;
    endtask

    task automatic cyc(input logic r, input logic tki, input logic w,
                       input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        #1;
        rst = r; src = cur_src; sup = cur_sup; tk = tki; we = w; addr = a; wd = d;
        if (m_valid) pre_q.push_back(m_read(a));
        if (tki && m_st == 2'd1)
            $display("txn: cycle %0d irq id=%0d taken", cyc_n, m_id);
        m_step(r, cur_src, cur_sup, tki, w, a, d);
        if (r) m_valid = 1'b1;
        if (m_valid) post_q.push_back({m_irq, m_id, m_act, m_read(a)});
        cyc_n++;
    endtask

    task automatic idle(input logic [1:0] a);
        cyc(1'b0, 1'b0, 1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic take();
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 32'h0);
    endtask

    // Monitor: combinational read before the edge, registered outputs after it.
    initial begin
        logic [31:0] ep;
        logic [36:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (pre_q.size() > 0) begin
                ep = pre_q.pop_front();
                checks++;
                if (rdata !== ep) begin
                    errors++;
                    $display("FAIL rdata_pre t=%0t got=%h exp=%h", $time, rdata, ep);
                end
            end
            @(posedge clk);
            #1;
            if (post_q.size() > 0) begin
                e = post_q.pop_front();
                checks += 4;
                if (irq !== e[36]) begin
                    errors++;
                    $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, e[36]);
                end
                if (id !== e[35:33]) begin
                    errors++;
                    $display("FAIL irq_id t=%0t got=%0d exp=%0d", $time, id, e[35:33]);
                end
                if (act !== e[32]) begin
                    errors++;
                    $display("FAIL irq_active t=%0t got=%b exp=%b", $time, act, e[32]);
                end
                if (rdata !== e[31:0]) begin
                    errors++;
                    $display("FAIL rdata_post t=%0t got=%h exp=%h", $time, rdata, e[31:0]);
                end
            end
        end
    end

    initial begin
        logic       r, tki, w;
        logic [1:0] a;
        logic [31:0] d;

        cyc(1'b1, 1'b0, 1'b0, 2'd1, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 32'h0);

        // Single edge on source 3, take, EOI
        wr(2'd1, 32'hFF);
        cur_src = 8'h08; idle(2'd0);
        cur_src = 8'h00; idle(2'd0);
        idle(2'd3); idle(2'd3);
        take(); idle(2'd0);
        wr(2'd2, 32'h0); idle(2'd2); idle(2'd3);

        // Simultaneous edges: lowest index first, the other follows after EOI
        cur_src = 8'h22; idle(2'd0);
        cur_src = 8'h00; idle(2'd3); idle(2'd3);
        take(); idle(2'd0);
        wr(2'd2, 32'h0); idle(2'd3); idle(2'd3);
        take(); wr(2'd2, 32'h0); idle(2'd3);

        // Supervisor holds off, then release; mask withdraws; W1C racing a rise
        wr(2'd1, 32'h04);
        cur_sup = 1'b1; cur_src = 8'h04; idle(2'd3); idle(2'd3); idle(2'd0);
        cur_sup = 1'b0; idle(2'd3); idle(2'd3);
        wr(2'd1, 32'h0); idle(2'd3); idle(2'd0);
        cur_src = 8'h00; idle(2'd0);
        cur_src = 8'h04; wr(2'd0, 32'h04);
        cur_src = 8'h00; idle(2'd0);

        // Edges accumulate during service; stray take is ignored
        wr(2'd1, 32'hFF); idle(2'd3); idle(2'd3);
        take(); cur_src = 8'h01; idle(2'd3);
        cur_src = 8'h00; idle(2'd3);
        take(); idle(2'd2);
        wr(2'd2, 32'h0); idle(2'd3); idle(2'd3);

        // Reset in REQUEST, then in SERVICE
        cyc(1'b1, 1'b0, 1'b0, 2'd1, 32'h0); idle(2'd1);
        wr(2'd1, 32'hFF);
        cur_src = 8'h80; idle(2'd3);
        cur_src = 8'h00; idle(2'd3); idle(2'd3);
        take(); idle(2'd2);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'h0); idle(2'd1); idle(2'd3);

        // Randomised traffic
        repeat (1200) begin
            r = ($urandom_range(0, 249) == 0);
            cur_src = cur_src ^ 8'($urandom & $urandom & $urandom);
            cur_sup = ($urandom_range(0, 9) == 0);
            tki = ((m_st == 2'd1) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 24) == 0);
            w = ($urandom_range(0, 5) == 0);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd0) d = d & $urandom & $urandom;
            if (a == 2'd1) d = d | $urandom;
            if (m_st == 2'd2 && $urandom_range(0, 3) == 0) begin
                w = 1'b1; a = 2'd2;
            end
            cyc(r, tki, w, a, d);
        end
        idle(2'd3);

        @(posedge clk);
        #3;
        if (pre_q.size() != 0 || post_q.size() != 0) begin
            errors++;
            $display("FAIL drain pre=%0d post=%0d exp=0", pre_q.size(), post_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout t=%0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
